// File: rtl/reg_file_16x16_pkg.sv
// ============================================================================
// Module : reg_file_pkg
// Brief  : Shared types, sizes and the 4-to-16 wordline decoder for the
//          decode-stage register file.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int REG_ID_W = 4;
  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 16;

  typedef logic [3:0]  reg_id_t;
  typedef logic [15:0] reg_data_t;
  typedef logic [15:0] wordline_t;

  // One-hot wordline for a register ID; every ID sets exactly one bit.
  function automatic wordline_t decode_4to16(input reg_id_t id);
    decode_4to16 = wordline_t'(1) << id;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_16x16_if.sv
// ============================================================================
// Module : reg_file_16x16_if
// Brief  : Read/write port bundle of the register file. The pipeline side
//          uses the master modport, the register file uses slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_16x16_if;
  import reg_file_pkg::*;

  reg_id_t   SrcReg1;
  reg_id_t   SrcReg2;
  reg_id_t   DstReg;
  logic      WriteReg;
  reg_data_t DstData;
  reg_data_t SrcData1;
  reg_data_t SrcData2;

  modport master (
    output SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
    input  SrcData1, SrcData2
  );

  modport slave (
    input  SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
    output SrcData1, SrcData2
  );

endinterface

`default_nettype wire

// File: rtl/reg_file_16x16_reg_word.sv
// ============================================================================
// Module : reg_word
// Brief  : One 16-bit register with synchronous active-high clear and a
//          write enable. The clear has priority over the write.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_word
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_data_t d,
  output reg_data_t q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_16x16.sv
// ============================================================================
// Module : reg_file_16x16
// Brief  : 16 x 16-bit register file, two combinational read ports and one
//          clocked write port, driven by one-hot wordline selects.
//          Define REG_FILE_BYPASS_EN to forward same-cycle write data to
//          matching read ports.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_16x16 #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  reg_file_16x16_if.slave   bus
);
  import reg_file_pkg::*;

  wordline_t rd1_sel;
  wordline_t rd2_sel;
  wordline_t wr_sel;
  reg_data_t words [NUM_REGS];
  reg_data_t stored1;
  reg_data_t stored2;

  assign rd1_sel = decode_4to16(bus.SrcReg1);
  assign rd2_sel = decode_4to16(bus.SrcReg2);
  assign wr_sel  = decode_4to16(bus.DstReg);

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
      reg_word u_word (
        .clk (clk),
        .rst (rst),
        .we  (bus.WriteReg & wr_sel[i]),
        .d   (bus.DstData),
        .q   (words[i])
      );
    end
  endgenerate

  // AND-OR read mux: with a one-hot select only one word reaches the output.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      stored1 = stored1 | (words[i] & {DATA_W{rd1_sel[i]}});
      stored2 = stored2 | (words[i] & {DATA_W{rd2_sel[i]}});
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic hit1;
  logic hit2;

  // Forwarding deliberately ignores rst; the forwarded value is never stored.
  assign hit1 = bus.WriteReg && (wr_sel == rd1_sel);
  assign hit2 = bus.WriteReg && (wr_sel == rd2_sel);

  assign bus.SrcData1 = hit1 ? bus.DstData : stored1;
  assign bus.SrcData2 = hit2 ? bus.DstData : stored2;
`else
  assign bus.SrcData1 = stored1;
  assign bus.SrcData2 = stored2;
`endif

endmodule

`default_nettype wire

// File: doc/reg_file_16x16.md
# reg_file_16x16

- 16-entry × 16-bit register file for the processor's decode stage.
- Sits directly downstream of the 4-to-16 read/write wordline decoders and consumes their one-hot selects.
- Two combinational read ports and one clocked write port.
- Optional write-to-read bypass, so a value written in cycle N is visible on a read in that same cycle N.

## Interface
Parameters:
- DATA_W, 16, register width in bits (fixed at 16 for this ISA).
- NUM_REGS, 16, register count (fixed; 4-bit register IDs).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- SrcReg1  input  4  read port 1 register ID.
- SrcReg2  input  4  read port 2 register ID.
- DstReg  input  4  write port register ID.
- WriteReg  input  1  write enable for the write port.
- DstData  input  16  write data.
- SrcData1  output  16  read port 1 data.
- SrcData2  output  16  read port 2 data.

## Operation
- Storage: 16 words of 16 bits each, R0–R15. All 16 are writable; there is no hardwired zero.
- Select decode: SrcReg1, SrcReg2 and DstReg are each decoded to one-hot 16-bit selects. Exactly one bit is set for each 4-bit value; the all-zero default is unreachable.
- Write:
  - Occurs on the rising edge of clk when WriteReg=1 and rst=0.
  - Word[DstReg] takes DstData; all other words hold their value.
  - When WriteReg=0, no word changes.
- Read:
  - Combinational: SrcDataN = Word[SrcRegN].
  - Both ports may address the same register and then return identical data.
- Bypass (when compiled in): if WriteReg=1 and DstReg==SrcRegN, SrcDataN = DstData in the same cycle instead of the stored value. This applies to each port independently.
- Reset:
  - While rst=1, every word clears to 16'h0000 at the next edge.
  - A write asserted in the same cycle as rst is discarded, because reset wins.
  - Bypass stays active during rst. The bypassed value is not stored.
- Reset mid-operation: on the edge after rst deasserts, all reads return 0 until the first write lands.

## Timing
- Write latency: 1 edge. Data presented in cycle N is stored at the end of cycle N.
- Read latency:
  - Without bypass: 0 cycles from SrcReg change, reflecting storage as of the last edge. A value written in cycle N is first readable in cycle N+1.
  - With bypass: a value written in cycle N is readable in cycle N, through the combinational path DstData → SrcDataN.
- Reset values: all 16 words = 0. After reset, SrcData1 and SrcData2 = 16'h0000 for any SrcReg, except when a bypass match is active.
- No handshake: the write port is fire-and-forget with no stall or back-pressure.
- Simultaneous read and write to the same register:
  - Bypass build: the read returns the new data.
  - Non-bypass build: the read returns the old data.

## Configuration
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-to-read bypass is present, per port, as described in Operation.
- Undefined: no bypass mux. Reads return stored contents only, and the pipeline must add one cycle of write-to-read distance.

## Structure
- Shared package (reg_file_pkg):
  - REG_ID_W = 4
  - DATA_W = 16
  - NUM_REGS = 16
  - typedef reg_id_t (logic [3:0])
  - typedef reg_data_t (logic [15:0])
  - typedef wordline_t (logic [15:0])
- Sub-module: reg_word. One 16-bit register with synchronous active-high clear and write enable, instantiated 16 times. Its write enable is WriteReg AND the matching bit of the write wordline.
- The decoders (two read, one write) are existing blocks instantiated at this level.

## Test plan
- Reset clear:
  - Stimulus: write 16'hFFFF to all 16 registers, then hold rst=1 for one edge.
  - Required: reading every ID returns 16'h0000.
- Write then read:
  - Stimulus: cycle 0 writes R5=16'hA5A5; cycle 1 reads SrcReg1=5 and SrcReg2=5.
  - Required: both ports show 16'hA5A5, and R4 and R6 are still 16'h0000.
- Same-cycle read and write to R3:
  - Stimulus: R3 already holds 16'h1111; write DstData=16'h2222 with SrcReg1=3.
  - Required: with REG_FILE_BYPASS_EN, SrcData1=16'h2222 in that cycle. Without it, SrcData1=16'h1111, then 16'h2222 in the next cycle.
- Write enable low:
  - Stimulus: DstReg=7, DstData=16'hBEEF, WriteReg=0 for one edge.
  - Required: R7 stays 16'h0000, and no bypass occurs even when SrcReg2=7.
- Reset with write:
  - Stimulus: rst=1 and WriteReg=1, DstReg=15, DstData=16'h1234 in the same cycle.
  - Required: after the edge, R15=16'h0000.
- Distinct ports, full sweep:
  - Stimulus: write R{i}=16'h0100+i for i=0..15, then sweep SrcReg1=i and SrcReg2=15-i.
  - Required: the outputs match the written values on every cycle.
